obi_data_bus_demux: RTL and testbench
=====================================

Name: obi_data_bus_demux

Overview:
- Parametrised 1-to-N demultiplexer for the CV32E40P OBI-style data port (addr/req/we/be/wdata/gnt/rvalid/rdata).
- Sits between the core data master and N memory/peripheral slaves (data RAM, UART, timers, ...).
- Decodes each request against a per-slave base/mask map and forwards it to one slave.
- Tracks outstanding transactions so responses return in order; unmapped addresses get a local error response.

Parameters:
- N_SLAVES, 2, number of downstream slave ports (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (1..15).
- SLV_BASE, all zeros, packed N_SLAVES*ADDR_W; base address of slave k at bits [k*ADDR_W +: ADDR_W].
- SLV_MASK, all zeros, packed N_SLAVES*ADDR_W; decode mask of slave k.
- ERR_RDATA, 32'hBADC0DE5, rdata returned for unmapped accesses; zero-extended or truncated to DATA_W.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- m_req_i  in  1  master request.
- m_addr_i  in  ADDR_W  master address.
- m_we_i  in  1  write enable.
- m_be_i  in  DATA_W/8  byte enables.
- m_wdata_i  in  DATA_W  write data.
- m_gnt_o  out  1  grant to master.
- m_rvalid_o  out  1  response valid to master.
- m_rdata_o  out  DATA_W  response data.
- m_err_o  out  1  response is a decode error; qualified by m_rvalid_o.
- s_req_o  out  N_SLAVES  per-slave request.
- s_addr_o  out  N_SLAVES*ADDR_W  per-slave address (broadcast).
- s_we_o  out  N_SLAVES  per-slave write enable (broadcast).
- s_be_o  out  N_SLAVES*DATA_W/8  per-slave byte enables (broadcast).
- s_wdata_o  out  N_SLAVES*DATA_W  per-slave write data (broadcast).
- s_gnt_i  in  N_SLAVES  per-slave grant.
- s_rvalid_i  in  N_SLAVES  per-slave response valid.
- s_rdata_i  in  N_SLAVES*DATA_W  per-slave response data.
- spurious_rsp_o  out  1  one-cycle pulse on an unexpected slave rvalid.

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset state: outstanding count = 0, last target = 0, err_rvalid_q = 0, spurious_rsp_o = 0. With count 0, m_rvalid_o = 0 and m_err_o = 0.
- Decode (combinational): slave k hits if (m_addr_i & SLV_MASK[k]) == SLV_BASE[k].
  - If several slaves hit, the lowest index wins.
  - If no slave hits, the target is ERR (internal id N_SLAVES).
- Stall condition: stall = (count == MAX_OUTSTANDING) OR (count != 0 AND target != last_target). This enforces in-order responses without reordering.
- Request path (combinational, zero latency):
  - s_req_o[k] = m_req_i & (target==k) & !stall.
  - m_gnt_o = !stall & m_req_i & (target==ERR ? 1 : s_gnt_i[target]).
  - addr/we/be/wdata are broadcast unchanged to all slaves.
- Handshake: an accepted request is m_req_i & m_gnt_o. On acceptance, last_target <= target.
  - The master must hold the request stable until granted (OBI rule); the block does not check this.
- Response path:
  - For a slave target: m_rvalid_o = (count != 0) & (last_target != ERR) & s_rvalid_i[last_target]; m_rdata_o = s_rdata_i[last_target]; m_err_o = 0.
  - For ERR: err_rvalid_q <= (accepted & target==ERR), so the error response comes exactly 1 cycle after grant. Then m_rvalid_o = 1, m_rdata_o = ERR_RDATA, m_err_o = 1.
  - Writes and reads are handled identically.
  - m_rdata_o is don't-care when m_rvalid_o = 0; drive 0.
- Counter:
  - count <= count + accepted - m_rvalid_o.
  - An accept and a response in the same cycle leave count unchanged.
  - Width is $clog2(MAX_OUTSTANDING+1). Overflow and underflow are impossible by construction; assert this in simulation.
- Spurious response: any s_rvalid_i[k] with count == 0 or k != last_target.
  - spurious_rsp_o is registered and pulses 1 cycle later.
  - The spurious response is dropped and never forwarded.
- Back-to-back accesses to the same target: one accept per cycle is allowed.
- Switching target: waits until count reaches 0. The cycle in which the last response arrives does not yet unstall; the grant comes the next cycle, because count is registered.
- Reset mid-transaction: all state clears. Responses from slaves that arrive after reset count as spurious.

Test Plan:
- N_SLAVES=2, SLV_BASE={0x1000_0000, 0x0000_0000}, SLV_MASK={0xF000_0000, 0xF000_0000}; read 0x0000_0010, slave0 gnt immediate, rvalid +1 cycle with rdata 0x12345678 -> m_gnt_o=1 same cycle, m_rvalid_o=1 with 0x12345678, m_err_o=0.
- Read 0x2000_0000 (unmapped) -> m_gnt_o=1 same cycle; next cycle m_rvalid_o=1, m_rdata_o=0xBADC0DE5, m_err_o=1; no s_req_o asserted.
- MAX_OUTSTANDING=2; three back-to-back reads to slave0 with slave withholding rvalid -> first two granted, third stalled (m_gnt_o=0, s_req_o[0]=0) until the first rvalid; grant arrives the following cycle.
- Read slave0 (outstanding), then request slave1 -> s_req_o[1]=0 until slave0 responds and count=0; then granted; responses arrive in issue order.
- s_rvalid_i[1]=1 while idle -> m_rvalid_o=0, spurious_rsp_o=1 for exactly one cycle.
- Assert rst_i for one cycle with 2 outstanding -> next cycle count=0, m_rvalid_o=0, a new request to slave1 is granted immediately.

Source files
------------

// File: rtl/obi_data_bus_demux.sv
// 1-to-N demultiplexer for an OBI-style data port with base/mask address decode,
// in-order response tracking and a local error responder for unmapped addresses.
module obi_data_bus_demux #(
  parameter int                          N_SLAVES        = 2,
  parameter int                          ADDR_W          = 32,
  parameter int                          DATA_W          = 32,
  parameter int                          MAX_OUTSTANDING = 2,
  parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_BASE        = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_MASK        = '0,
  parameter logic [31:0]                 ERR_RDATA       = 32'hBADC0DE5
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                m_req_i,
  input  logic [ADDR_W-1:0]                   m_addr_i,
  input  logic                                m_we_i,
  input  logic [DATA_W/8-1:0]                 m_be_i,
  input  logic [DATA_W-1:0]                   m_wdata_i,
  output logic                                m_gnt_o,
  output logic                                m_rvalid_o,
  output logic [DATA_W-1:0]                   m_rdata_o,
  output logic                                m_err_o,
  output logic [N_SLAVES-1:0]                 s_req_o,
  output logic [N_SLAVES*ADDR_W-1:0]          s_addr_o,
  output logic [N_SLAVES-1:0]                 s_we_o,
  output logic [N_SLAVES*(DATA_W/8)-1:0]      s_be_o,
  output logic [N_SLAVES*DATA_W-1:0]          s_wdata_o,
  input  logic [N_SLAVES-1:0]                 s_gnt_i,
  input  logic [N_SLAVES-1:0]                 s_rvalid_i,
  input  logic [N_SLAVES*DATA_W-1:0]          s_rdata_i,
  output logic                                spurious_rsp_o
);

  localparam int ID_W  = $clog2(N_SLAVES + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ID_W-1:0]   ERR_ID   = ID_W'(N_SLAVES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_RDATA);

  logic [CNT_W-1:0]  count;
  logic [ID_W-1:0]   last_target;
  logic              err_rvalid_q;
  logic [ID_W-1:0]   target;
  logic              tgt_gnt;
  logic              stall;
  logic              accepted;
  logic              sel_rvalid;
  logic [DATA_W-1:0] sel_rdata;
  logic              slave_rvalid;
  logic              spur_any;

  // Iterating downwards lets the lowest matching slave index win.
  always_comb begin
    target = ERR_ID;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if ((m_addr_i & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W])
        target = ID_W'(k);
    end
  end

  always_comb begin
    tgt_gnt = (target == ERR_ID);
    s_req_o = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (target == ID_W'(k)) begin
        tgt_gnt    = s_gnt_i[k];
        s_req_o[k] = m_req_i & ~stall;
      end
    end
  end

  // Holding off a target switch until the pipe drains keeps responses in order.
  assign stall    = (count == CNT_MAX) || ((count != '0) && (target != last_target));
  assign m_gnt_o  = ~stall & m_req_i & tgt_gnt;
  assign accepted = m_req_i & m_gnt_o;

  assign s_addr_o  = {N_SLAVES{m_addr_i}};
  assign s_we_o    = {N_SLAVES{m_we_i}};
  assign s_be_o    = {N_SLAVES{m_be_i}};
  assign s_wdata_o = {N_SLAVES{m_wdata_i}};

  // ERR_ID never matches a slave index, so an error target selects nothing here.
  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    spur_any   = 1'b0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (last_target == ID_W'(k)) begin
        sel_rvalid = s_rvalid_i[k];
        sel_rdata  = s_rdata_i[k*DATA_W +: DATA_W];
      end
      if (s_rvalid_i[k] && ((count == '0) || (last_target != ID_W'(k))))
        spur_any = 1'b1;
    end
  end

  assign slave_rvalid = (count != '0) & sel_rvalid;
  assign m_rvalid_o   = err_rvalid_q | slave_rvalid;
  assign m_err_o      = err_rvalid_q;
  assign m_rdata_o    = err_rvalid_q ? ERR_DATA : (slave_rvalid ? sel_rdata : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count          <= '0;
      last_target    <= '0;
      err_rvalid_q   <= 1'b0;
      spurious_rsp_o <= 1'b0;
    end else begin
      count          <= count + CNT_W'(accepted) - CNT_W'(m_rvalid_o);
      err_rvalid_q   <= accepted & (target == ERR_ID);
      spurious_rsp_o <= spur_any;
      if (accepted)
        last_target <= target;
    end
  end

  // The stall logic must make counter overflow and underflow unreachable.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(accepted && !m_rvalid_o && (count == CNT_MAX)));
      assert (!(m_rvalid_o && !accepted && (count == '0)));
    end
  end

endmodule

// File: tb/tb_obi_data_bus_demux.sv
// Bench for obi_data_bus_demux: directed scenarios followed by random traffic,
// all checked against a queue-based model of outstanding transactions.
module tb_obi_data_bus_demux;

  localparam int MAX_OUT = 2;
  localparam int ERR_T   = 2;
  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h1000_0000;
  localparam logic [31:0] AE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt, m_rvalid, m_err;
  logic [31:0] m_rdata;
  logic [1:0]  s_req, s_we, s_gnt, s_rvalid;
  logic [63:0] s_addr, s_wdata, s_rdata;
  logic [7:0]  s_be;
  logic        spur;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of targets granted but not yet answered.
  int          pend[$];
  bit          err_due;
  bit          spur_q;
  bit          hold;
  logic        exp_gnt, exp_rvalid, exp_err;
  logic [1:0]  exp_sreq;
  logic [31:0] exp_rdata;
  int          exp_tgt, exp_front;
  logic [31:0] base_a [2] = '{32'h0000_0000, 32'h1000_0000};
  logic [31:0] mask_a [2] = '{32'hF000_0000, 32'hF000_0000};

  always #5 clk = ~clk;

  obi_data_bus_demux #(
    .N_SLAVES(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAX_OUT),
    .SLV_BASE({32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK({32'hF000_0000, 32'hF000_0000}),
    .ERR_RDATA(32'hBADC0DE5)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
    .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .spurious_rsp_o(spur)
  );

  function automatic int decode(logic [31:0] a);
    for (int k = 0; k < 2; k++)
      if ((a & mask_a[k]) == base_a[k]) return k;
    return ERR_T;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current inputs and model state, compared against the DUT.
  task automatic modelEvalAndCheck();
    int  cnt;
    bit  stall;
    bit  slave_rv;
    cnt       = pend.size();
    exp_tgt   = decode(m_addr);
    exp_front = (cnt > 0) ? pend[0] : -1;
    stall     = (cnt == MAX_OUT) || (cnt > 0 && exp_tgt != pend[cnt-1]);
    exp_sreq  = (m_req && !stall && exp_tgt < ERR_T) ? (2'b01 << exp_tgt) : 2'b00;
    exp_gnt   = m_req && !stall && (exp_tgt == ERR_T || s_gnt[exp_tgt] == 1'b1);
    slave_rv  = (exp_front >= 0) && (exp_front < ERR_T) && (s_rvalid[exp_front] == 1'b1);
    exp_rvalid = err_due || slave_rv;
    exp_err    = err_due;
    exp_rdata  = err_due ? 32'hBADC0DE5 : (slave_rv ? s_rdata[exp_front*32 +: 32] : 32'h0);
    checkOutput("gnt",    {63'h0, m_gnt},    {63'h0, exp_gnt});
    checkOutput("s_req",  {62'h0, s_req},    {62'h0, exp_sreq});
    checkOutput("rvalid", {63'h0, m_rvalid}, {63'h0, exp_rvalid});
    checkOutput("rdata",  {32'h0, m_rdata},  {32'h0, exp_rdata});
    checkOutput("err",    {63'h0, m_err},    {63'h0, exp_err});
    checkOutput("spur",   {63'h0, spur},     {63'h0, 1'b0 ^ spur_q});
    checkOutput("s_addr", s_addr, {m_addr, m_addr});
    checkOutput("s_wdata", s_wdata, {m_wdata, m_wdata});
    checkOutput("s_be_we", {54'h0, s_be, s_we}, {54'h0, m_be, m_be, m_we, m_we});
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic [1:0] g,
                               input logic [1:0] rv, input logic [31:0] d0,
                               input logic [31:0] d1, input logic rs);
    m_req    = r;
    m_addr   = a;
    m_we     = 1'($urandom_range(0, 1));
    m_be     = 4'($urandom_range(0, 15));
    m_wdata  = $urandom();
    s_gnt    = g;
    s_rvalid = rv;
    s_rdata  = {d1, d0};
    rst      = rs;
    #3;
    modelEvalAndCheck();
  endtask

  // Advance one clock and update the model with what happened on that edge.
  task automatic endCycle();
    bit spur_next;
    bit acc;
    @(posedge clk);
    if (rst) begin
      pend.delete();
      err_due = 0;
      spur_q  = 0;
      hold    = 0;
    end else begin
      spur_next = 0;
      for (int k = 0; k < 2; k++)
        if (s_rvalid[k] && exp_front != k) spur_next = 1;
      acc = m_req && exp_gnt;
      if (exp_rvalid) void'(pend.pop_front());
      if (acc) pend.push_back(exp_tgt);
      err_due = acc && (exp_tgt == ERR_T);
      spur_q  = spur_next;
      hold    = m_req && !exp_gnt;
    end
    #1;
  endtask

  initial begin
    logic        r;
    logic [31:0] ra;
    logic [31:0] region;

    m_req = 0; m_addr = 0; m_we = 0; m_be = 0; m_wdata = 0;
    s_gnt = 0; s_rvalid = 0; s_rdata = 0; rst = 1;
    err_due = 0; spur_q = 0; hold = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;

    // Idle after reset
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 0, 0);
    checkOutput("reset_rvalid", {63'h0, m_rvalid}, 64'h0);
    checkOutput("reset_spur", {63'h0, spur}, 64'h0);
    endCycle();

    // Simple read from slave0
    applyStimulus(1, A0, 2'b01, 2'b00, 0, 0, 0);
    checkOutput("t1_gnt", {63'h0, m_gnt}, 64'h1);
    endCycle();
    applyStimulus(0, A0, 2'b01, 2'b01, 32'h12345678, 0, 0);
    checkOutput("t1_rvalid", {63'h0, m_rvalid}, 64'h1);
    checkOutput("t1_rdata", {32'h0, m_rdata}, 64'h12345678);
    checkOutput("t1_err", {63'h0, m_err}, 64'h0);
    endCycle();

    // Unmapped read answered locally
    applyStimulus(1, AE, 2'b00, 2'b00, 0, 0, 0);
    checkOutput("err_gnt", {63'h0, m_gnt}, 64'h1);
    checkOutput("err_sreq", {62'h0, s_req}, 64'h0);
    endCycle();
    applyStimulus(0, AE, 2'b00, 2'b00, 0, 0, 0);
    checkOutput("err_rvalid", {63'h0, m_rvalid}, 64'h1);
    checkOutput("err_rdata", {32'h0, m_rdata}, 64'hBADC0DE5);
    checkOutput("err_flag", {63'h0, m_err}, 64'h1);
    endCycle();

    // Outstanding limit: third read stalls until one response has been counted
    applyStimulus(1, A0, 2'b01, 2'b00, 0, 0, 0);
    checkOutput("lim_gnt1", {63'h0, m_gnt}, 64'h1);
    endCycle();
    applyStimulus(1, A0 + 4, 2'b01, 2'b00, 0, 0, 0);
    checkOutput("lim_gnt2", {63'h0, m_gnt}, 64'h1);
    endCycle();
    applyStimulus(1, A0 + 8, 2'b01, 2'b00, 0, 0, 0);
    checkOutput("lim_stall_gnt", {63'h0, m_gnt}, 64'h0);
    checkOutput("lim_stall_sreq", {62'h0, s_req}, 64'h0);
    endCycle();
    applyStimulus(1, A0 + 8, 2'b01, 2'b01, 32'hAAAA0001, 0, 0);
    checkOutput("lim_rsp_gnt", {63'h0, m_gnt}, 64'h0);
    checkOutput("lim_rsp_rdata", {32'h0, m_rdata}, 64'hAAAA0001);
    endCycle();
    applyStimulus(1, A0 + 8, 2'b01, 2'b00, 0, 0, 0);
    checkOutput("lim_gnt3", {63'h0, m_gnt}, 64'h1);
    endCycle();
    applyStimulus(0, 0, 2'b00, 2'b01, 32'hAAAA0002, 0, 0);
    endCycle();
    applyStimulus(0, 0, 2'b00, 2'b01, 32'hAAAA0003, 0, 0);
    checkOutput("lim_last_rdata", {32'h0, m_rdata}, 64'hAAAA0003);
    endCycle();

    // Target switch waits for slave0 to drain
    applyStimulus(1, A0, 2'b11, 2'b00, 0, 0, 0);
    endCycle();
    applyStimulus(1, A1, 2'b11, 2'b00, 0, 0, 0);
    checkOutput("sw_stall_sreq", {62'h0, s_req}, 64'h0);
    endCycle();
    applyStimulus(1, A1, 2'b11, 2'b01, 32'h0000BEEF, 0, 0);
    checkOutput("sw_drain_gnt", {63'h0, m_gnt}, 64'h0);
    checkOutput("sw_drain_rdata", {32'h0, m_rdata}, 64'h0000BEEF);
    endCycle();
    applyStimulus(1, A1, 2'b11, 2'b00, 0, 0, 0);
    checkOutput("sw_gnt", {63'h0, m_gnt}, 64'h1);
    checkOutput("sw_sreq", {62'h0, s_req}, 64'h2);
    endCycle();
    applyStimulus(0, 0, 2'b00, 2'b10, 0, 32'hCAFE0001, 0);
    checkOutput("sw_rdata", {32'h0, m_rdata}, 64'hCAFE0001);
    endCycle();

    // Spurious response while idle
    applyStimulus(0, 0, 2'b00, 2'b10, 0, 32'h1, 0);
    checkOutput("spur_rvalid", {63'h0, m_rvalid}, 64'h0);
    endCycle();
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 0, 0);
    checkOutput("spur_pulse", {63'h0, spur}, 64'h1);
    endCycle();
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 0, 0);
    checkOutput("spur_end", {63'h0, spur}, 64'h0);
    endCycle();

    // Reset with two outstanding, then a fresh request to slave1
    applyStimulus(1, A0, 2'b01, 2'b00, 0, 0, 0);
    endCycle();
    applyStimulus(1, A0, 2'b01, 2'b00, 0, 0, 0);
    endCycle();
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 0, 1);
    endCycle();
    applyStimulus(1, A1, 2'b10, 2'b00, 0, 0, 0);
    checkOutput("rst_gnt", {63'h0, m_gnt}, 64'h1);
    checkOutput("rst_rvalid", {63'h0, m_rvalid}, 64'h0);
    endCycle();
    applyStimulus(0, 0, 2'b00, 2'b10, 0, 32'h5555AAAA, 0);
    endCycle();

    // Random traffic; the master holds an ungranted request stable
    r  = 0;
    ra = 0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        r      = ($urandom_range(0, 3) != 0);
        region = $urandom_range(0, 2);
        ra     = ($urandom() & 32'h0FFF_FFFF) | (region << 28);
      end
      applyStimulus(r, ra, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom(), $urandom(), $urandom_range(0, 63) == 0);
      endCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
